// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: configuration registers in, channel drive and period marker out.
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;
    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        input  out, period_start
    );
    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        output out, period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 channels, each forced low, forced high or on a shared PWM level.
// Duty is shadowed and reloaded only at the period boundary so outputs never glitch.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic            clk,
    input  logic            rst,
    pwm_peripheral_if.slave bus
);
    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
    logic [15:0] presc_q, presc_d, out_q, out_d, en_out, en_pwm;
    logic [7:0]  cnt_q, cnt_d, duty_q, duty_d;
    logic        ps_q, ps_d, tick, boundary, level;
    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    always_comb begin
        tick     = presc_q == LAST;
        boundary = tick && cnt_q == 8'hFF;
        // 0xFF is full-on rather than 255/256 so a channel can be held high in PWM mode
        level    = duty_q == 8'hFF || cnt_q < duty_q;
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
        duty_d   = boundary ? bus.pwm_duty_cycle : duty_q;
        ps_d     = boundary;
        out_d    = en_out & (~en_pwm | {16{level}});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            out_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            out_q   <= out_d;
            ps_q    <= ps_d;
        end
    end
    assign bus.out          = out_q;
    assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: two instances (CLK_DIV 1 and 3) checked cycle by cycle against an
// elapsed-time reference model, plus direct duty/period measurements.
module tb_pwm_peripheral;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] en_out = 16'hFFFF;
    logic [15:0] en_pwm = 16'hFFFF;
    logic [7:0]  duty = 8'hFF;
    int          checks = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    pwm_peripheral_if b0 ();
    pwm_peripheral_if b1 ();
    assign b0.en_reg_out_7_0  = en_out[7:0];
    assign b0.en_reg_out_15_8 = en_out[15:8];
    assign b0.en_reg_pwm_7_0  = en_pwm[7:0];
    assign b0.en_reg_pwm_15_8 = en_pwm[15:8];
    assign b0.pwm_duty_cycle  = duty;
    assign b1.en_reg_out_7_0  = en_out[7:0];
    assign b1.en_reg_out_15_8 = en_out[15:8];
    assign b1.en_reg_pwm_7_0  = en_pwm[7:0];
    assign b1.en_reg_pwm_15_8 = en_pwm[15:8];
    assign b1.pwm_duty_cycle  = duty;

    pwm_peripheral #(.CLK_DIV(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    pwm_peripheral #(.CLK_DIV(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    // Reference model: state derived from the number of non-reset edges elapsed.
    int          n [2];
    logic [7:0]  sh [2];
    logic [16:0] q0 [$];
    logic [16:0] q1 [$];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int d, cnt;
            bit lvl, bnd;
            logic [15:0] e;
            d = (k == 1) ? 3 : 1;
            e = '0;
            bnd = 1'b0;
            if (rst) begin
                n[k] = 0;
                sh[k] = 8'h00;
            end else begin
                cnt = (n[k] / d) % 256;
                lvl = (sh[k] == 8'hFF) || (cnt < int'(sh[k]));
                for (int i = 0; i < 16; i++) e[i] = en_out[i] && (!en_pwm[i] || lvl);
                bnd = (n[k] % (256 * d)) == (256 * d - 1);
                if (bnd) sh[k] = duty;
                n[k]++;
            end
            if (k == 0) q0.push_back({bnd, e});
            else        q1.push_back({bnd, e});
        end
    end

    always @(negedge clk) begin
        logic [16:0] x;
        if (q0.size() > 0) begin
            x = q0.pop_front();
            checks++;
            if ({b0.period_start, b0.out} !== x) begin
                errs++;
                $display("FAIL sb0 t=%0t got ps=%b out=%h expected ps=%b out=%h",
                         $time, b0.period_start, b0.out, x[16], x[15:0]);
            end
        end
        if (q1.size() > 0) begin
            x = q1.pop_front();
            checks++;
            if ({b1.period_start, b1.out} !== x) begin
                errs++;
                $display("FAIL sb1 t=%0t got ps=%b out=%h expected ps=%b out=%h",
                         $time, b1.period_start, b1.out, x[16], x[15:0]);
            end
        end
    end

    function automatic logic ps_of(input int k);
        return (k == 1) ? b1.period_start : b0.period_start;
    endfunction

    // Waits for a period start, then counts high cycles of channel 0 over one full period.
    task automatic measure(input int k, input int exp_high, input int change_at,
                           input logic [7:0] new_duty, input string nm);
        int d, w, hi;
        d = (k == 1) ? 3 : 1;
        w = 0;
        while (!ps_of(k) && w < 256 * d + 8) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!ps_of(k)) begin
            errs++;
            $display("FAIL %s no period_start within %0d cycles", nm, w);
            return;
        end
        hi = 0;
        for (int i = 0; i < 256 * d; i++) begin
            @(negedge clk);
            if (((k == 1) ? b1.out[0] : b0.out[0]) === 1'b1) hi++;
            if (i == change_at) duty = new_duty;
        end
        checks++;
        if (hi != exp_high) begin
            errs++;
            $display("FAIL %s high cycles got %0d expected %0d", nm, hi, exp_high);
        end
        checks++;
        if (ps_of(k) !== 1'b1) begin
            errs++;
            $display("FAIL %s_spacing period_start got %b expected 1 after %0d cycles", nm, ps_of(k), 256 * d);
        end
    endtask

    task automatic check16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        int w, w0, w1;
        repeat (2) @(negedge clk);
        check16("reset_out", b0.out, 16'h0000);
        check16("reset_ps", {15'd0, b0.period_start}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check16("pre_boundary_out", b0.out, 16'h0000);
        measure(0, 256, -1, 8'h00, "duty255_first");

        en_out = 16'h00FF;
        en_pwm = 16'h000F;
        duty = 8'd0;
        @(negedge clk);
        measure(0, 0, -1, 8'h00, "static_duty0");
        repeat (2) @(negedge clk);
        check16("static_out", b0.out, 16'h00F0);
        en_out = 16'h0000;
        @(negedge clk);
        check16("disable_out", b0.out, 16'h0000);

        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty = 8'd128; @(negedge clk); measure(0, 128, -1, 8'h00, "duty128");
        duty = 8'd0;   @(negedge clk); measure(0, 0,   -1, 8'h00, "duty0");
        duty = 8'd1;   @(negedge clk); measure(0, 1,   -1, 8'h00, "duty1");
        duty = 8'd254; @(negedge clk); measure(0, 254, -1, 8'h00, "duty254");
        duty = 8'd255; @(negedge clk); measure(0, 256, -1, 8'h00, "duty255");

        duty = 8'd64; @(negedge clk);
        measure(0, 64, 100, 8'd192, "glitch_cur");
        measure(0, 192, 254, 8'd32, "bnd_cur");
        measure(0, 32, -1, 8'h00, "bnd_next");

        duty = 8'd128; @(negedge clk);
        measure(1, 384, -1, 8'h00, "div3");
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        w = 0; w0 = -1; w1 = -1;
        while (w1 < 0 && w < 900) begin
            @(negedge clk);
            w++;
            if (w0 < 0 && b0.period_start) w0 = w;
            if (w1 < 0 && b1.period_start) w1 = w;
        end
        check16("restart_div1", 16'(w0), 16'd256);
        check16("restart_div3", 16'(w1), 16'd768);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) duty = 8'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                en_out = 16'($urandom);
                en_pwm = 16'($urandom);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
